// File: rtl/d_input_debouncer.sv
// Synchronizes and debounces a raw level for the d input of a downstream latch,
// with one-cycle rise/fall strobes. Define DEBOUNCE_STATS_EN to build the glitch counter.
module d_input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_raw,
  output logic                d,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("d_input_debouncer: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
      $error("d_input_debouncer: STABLE_CYCLES must be in 2..255");
    end
    if (GLITCH_W < 1) begin : g_bad_glitch_w
      $error("d_input_debouncer: GLITCH_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_q, d_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer chain: d_raw enters at bit 0, s is the oldest sample.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Qualification FSM: a new level must be seen STABLE_CYCLES times in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          d_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          d_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        d_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign d    = d_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_STATS_EN
  logic                glitch_evt;
  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

  // An abort is a CHECK state seeing the old level again before qualifying.
  assign glitch_evt = ((state_q == CHECK_HIGH) && !s) || ((state_q == CHECK_LOW) && s);

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_evt && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule
